// File: rtl/shift_sequencer.sv
// ---------------------------------------------------------------------------
// shift_sequencer
//
// Multi-cycle controller sitting in front of the operand-2 barrel shifter.
// Takes one shift request at a time, optionally fetches the shift amount
// from Rs through a dedicated register-file read port, applies ARM shift
// semantics (immediate-zero encodings, saturation at 32+, RRX) and hands the
// registered result to the execute stage over a valid/ready handshake.
//
// Parameters:
//   RS_READ_LATENCY  cycles from rs_rd_en to valid rs_rd_data (1..3)
//   DATA_WIDTH       operand width, only 32 is supported
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous reset, active low
//   req_valid      request present
//   req_ready      sequencer idle and able to accept
//   req_type       00 LSL, 01 LSR, 10 ASR, 11 ROR
//   req_reg_shift  1 = amount from Rs[7:0], 0 = amount from req_imm_amount
//   req_imm_amount immediate shift amount
//   req_rs_addr    Rs register index
//   req_rm_data    Rm operand
//   carry_in       current C flag, sampled with the request
//   rs_rd_en       one-cycle Rs read strobe
//   rs_rd_addr     Rs read address, meaningful while rs_rd_en is high
//   rs_rd_data     Rs value, valid RS_READ_LATENCY cycles after the strobe
//   res_valid      result available
//   res_ready      consumer accepts the result
//   res_data       shifted result
//   res_carry      shifter carry-out (only with SHIFT_CARRY_OUT_EN)
//
// Build option:
//   SHIFT_CARRY_OUT_EN  when defined, adds res_carry and the carry-out logic.
// ---------------------------------------------------------------------------
module shift_sequencer #(
    parameter int RS_READ_LATENCY = 1,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_type,
    input  logic                  req_reg_shift,
    input  logic [4:0]            req_imm_amount,
    input  logic [3:0]            req_rs_addr,
    input  logic [DATA_WIDTH-1:0] req_rm_data,
    input  logic                  carry_in,
    output logic                  rs_rd_en,
    output logic [3:0]            rs_rd_addr,
    input  logic [DATA_WIDTH-1:0] rs_rd_data,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_data
`ifdef SHIFT_CARRY_OUT_EN
    ,
    output logic                  res_carry
`endif
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RS_REQ  = 3'd1;
    localparam logic [2:0] RS_WAIT = 3'd2;
    localparam logic [2:0] EXEC    = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    localparam logic [1:0] T_LSL = 2'b00;
    localparam logic [1:0] T_LSR = 2'b01;
    localparam logic [1:0] T_ASR = 2'b10;

    logic [2:0]            state_q, state_d;
    logic [1:0]            count_q, count_d;
    logic [7:0]            amount_q, amount_d;
    logic [1:0]            type_q;
    logic                  regShift_q;
    logic [4:0]            imm_q;
    logic [3:0]            rsAddr_q;
    logic [DATA_WIDTH-1:0] rm_q;
    logic                  cin_q;
    logic [DATA_WIDTH-1:0] res_q;

    logic [7:0]            effAmt;
    logic                  isRrx;
    logic [4:0]            shAmt;
    logic                  bigAmt;
    logic [31:0]           signMask;
    logic [31:0]           rorVal;
    logic [31:0]           resCalc;

    // Only the low byte of Rs is a shift amount; the rest is deliberately dropped.
    logic unusedRsBits;
    assign unusedRsBits = ^rs_rd_data[DATA_WIDTH-1:8];

    // Next-state logic. The Rs capture happens on the cycle the wait counter
    // is already zero, so RS_READ_LATENCY-1 extra wait cycles line up the
    // capture with the read data.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        amount_d = amount_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = req_reg_shift ? RS_REQ : EXEC;
                end
            end
            RS_REQ: begin
                count_d = 2'(RS_READ_LATENCY - 1);
                state_d = RS_WAIT;
            end
            RS_WAIT: begin
                if (count_q == 2'd0) begin
                    amount_d = rs_rd_data[7:0];
                    state_d  = EXEC;
                end else begin
                    count_d = count_q - 2'd1;
                end
            end
            EXEC: state_d = DONE;
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Immediate-zero encodings are folded into an effective 8-bit amount so
    // both amount sources share one set of shift rules; only RRX stays special.
    always_comb begin
        effAmt = regShift_q ? amount_q : {3'b000, imm_q};
        isRrx  = 1'b0;
        if (!regShift_q && imm_q == 5'd0) begin
            case (type_q)
                T_LSR, T_ASR: effAmt = 8'd32;
                T_LSL:        effAmt = 8'd0;
                default:      isRrx  = 1'b1;
            endcase
        end
    end

    assign shAmt    = effAmt[4:0];
    assign bigAmt   = |effAmt[7:5];
    assign signMask = ~(32'hFFFF_FFFF >> shAmt);
    assign rorVal   = (rm_q >> shAmt) | (rm_q << (6'd32 - {1'b0, shAmt}));

    // Shift datapath; ASR ORs in an explicit copy of the sign bit.
    always_comb begin
        resCalc = rm_q;
        if (isRrx) begin
            resCalc = {cin_q, rm_q[31:1]};
        end else if (effAmt != 8'd0) begin
            case (type_q)
                T_LSL:   resCalc = bigAmt ? 32'd0 : (rm_q << shAmt);
                T_LSR:   resCalc = bigAmt ? 32'd0 : (rm_q >> shAmt);
                T_ASR:   resCalc = bigAmt ? {32{rm_q[31]}}
                                          : ((rm_q >> shAmt) | (signMask & {32{rm_q[31]}}));
                default: resCalc = rorVal;
            endcase
        end
    end

`ifdef SHIFT_CARRY_OUT_EN
    logic [4:0] negAmt;
    logic       carryCalc;
    logic       carry_q;

    // Last bit shifted out; for LSL by n that is bit 32-n, i.e. -n mod 32.
    assign negAmt = 5'd0 - shAmt;

    always_comb begin
        carryCalc = cin_q;
        if (isRrx) begin
            carryCalc = rm_q[0];
        end else if (effAmt != 8'd0) begin
            case (type_q)
                T_LSL:   carryCalc = bigAmt ? ((effAmt == 8'd32) && rm_q[0])  : rm_q[negAmt];
                T_LSR:   carryCalc = bigAmt ? ((effAmt == 8'd32) && rm_q[31]) : rm_q[shAmt - 5'd1];
                T_ASR:   carryCalc = bigAmt ? rm_q[31] : rm_q[shAmt - 5'd1];
                default: carryCalc = rorVal[31];
            endcase
        end
    end

    assign res_carry = carry_q;
`endif

    // State, request latch and result register. The request is latched only
    // on the accepting edge, so later activity on the request port is ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            count_q    <= 2'd0;
            amount_q   <= 8'd0;
            type_q     <= 2'd0;
            regShift_q <= 1'b0;
            imm_q      <= 5'd0;
            rsAddr_q   <= 4'd0;
            rm_q       <= '0;
            cin_q      <= 1'b0;
            res_q      <= '0;
`ifdef SHIFT_CARRY_OUT_EN
            carry_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            amount_q <= amount_d;
            if (state_q == IDLE && req_valid) begin
                type_q     <= req_type;
                regShift_q <= req_reg_shift;
                imm_q      <= req_imm_amount;
                rsAddr_q   <= req_rs_addr;
                rm_q       <= req_rm_data;
                cin_q      <= carry_in;
            end
            if (state_q == EXEC) begin
                res_q <= resCalc;
`ifdef SHIFT_CARRY_OUT_EN
                carry_q <= carryCalc;
`endif
            end
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign rs_rd_en   = (state_q == RS_REQ);
    assign rs_rd_addr = rs_rd_en ? rsAddr_q : 4'd0;
    assign res_valid  = (state_q == DONE);
    assign res_data   = res_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// ---------------------------------------------------------------------------
// tb_shift_sequencer
//
// Self-checking bench for shift_sequencer with RS_READ_LATENCY=2. Directed
// steps cover reset, immediate-zero encodings, register saturation,
// backpressure and reset mid-operation, followed by randomized requests.
// Results are compared against a bit-serial ARM shift model.
// ---------------------------------------------------------------------------
module tb_shift_sequencer;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_type;
    logic        req_reg_shift;
    logic [4:0]  req_imm_amount;
    logic [3:0]  req_rs_addr;
    logic [31:0] req_rm_data;
    logic        carry_in;
    logic        rs_rd_en;
    logic [3:0]  rs_rd_addr;
    logic [31:0] rs_rd_data;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
`ifdef SHIFT_CARRY_OUT_EN
    logic        res_carry;
`endif

    int errors = 0;
    int checks = 0;

    // Register file contents seen through the Rs read port, plus the delay
    // line that models the read latency.
    logic [31:0] rf [16];
    logic        pipeEn [4];
    logic [3:0]  pipeAddr [4];

    shift_sequencer #(
        .RS_READ_LATENCY(LAT),
        .DATA_WIDTH(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_type(req_type),
        .req_reg_shift(req_reg_shift),
        .req_imm_amount(req_imm_amount),
        .req_rs_addr(req_rs_addr),
        .req_rm_data(req_rm_data),
        .carry_in(carry_in),
        .rs_rd_en(rs_rd_en),
        .rs_rd_addr(rs_rd_addr),
        .rs_rd_data(rs_rd_data),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data(res_data)
`ifdef SHIFT_CARRY_OUT_EN
        ,
        .res_carry(res_carry)
`endif
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Reference model: performs the shift one bit at a time, tracking the
    // last bit to fall out. Returns {carry, result}.
    function automatic logic [32:0] refShift(input logic [1:0] t, input logic isReg,
                                             input logic [4:0] imm, input logic [7:0] rsAmt,
                                             input logic [31:0] rm, input logic cin);
        int n;
        logic [31:0] x;
        logic c;
        logic rrx;
        x   = rm;
        c   = cin;
        rrx = 1'b0;
        if (isReg) n = int'(rsAmt);
        else if (imm != 5'd0) n = int'(imm);
        else if (t == 2'b00) n = 0;
        else if (t == 2'b11) begin n = 0; rrx = 1'b1; end
        else n = 32;
        if (rrx) begin
            c = x[0];
            x = {cin, x[31:1]};
        end else if (n != 0) begin
            if (t == 2'b11) n = (n % 32 == 0) ? 32 : n % 32;
            for (int i = 0; i < n; i++) begin
                case (t)
                    2'b00:   begin c = x[31]; x = {x[30:0], 1'b0}; end
                    2'b01:   begin c = x[0];  x = {1'b0, x[31:1]}; end
                    2'b10:   begin c = x[0];  x = {x[31], x[31:1]}; end
                    default: begin c = x[0];  x = {x[0], x[31:1]}; end
                endcase
            end
        end
        return {c, x};
    endfunction

    // Advance to the next falling edge and update the Rs read responder so
    // valid data appears exactly LAT cycles after the strobe, junk otherwise.
    task automatic nextCycle();
        @(negedge clk);
        for (int i = 3; i > 0; i--) begin
            pipeEn[i]   = pipeEn[i-1];
            pipeAddr[i] = pipeAddr[i-1];
        end
        pipeEn[0]   = rs_rd_en;
        pipeAddr[0] = rs_rd_addr;
        rs_rd_data  = pipeEn[LAT] ? rf[pipeAddr[LAT]] : $urandom();
    endtask

    // Drive the request port.
    task automatic applyStimulus(input logic v, input logic [1:0] t, input logic isReg,
                                 input logic [4:0] imm, input logic [3:0] addr,
                                 input logic [31:0] rm, input logic cin);
        req_valid      = v;
        req_type       = t;
        req_reg_shift  = isReg;
        req_imm_amount = imm;
        req_rs_addr    = addr;
        req_rm_data    = rm;
        carry_in       = cin;
    endtask

    // One comparison point.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drive junk on the idle request port.
    task automatic junkRequest(input logic v);
        applyStimulus(v, 2'($urandom()), 1'($urandom()), 5'($urandom()),
                      4'($urandom()), $urandom(), 1'($urandom()));
    endtask

    // Issue one request from IDLE, wait for the result, check it, optionally
    // hold it under backpressure, then release it.
    task automatic runOp(input logic [1:0] t, input logic isReg, input logic [4:0] imm,
                         input logic [3:0] addr, input logic [31:0] rm, input logic cin,
                         input int hold);
        logic [32:0] exp;
        int k;
        int pulses;
        logic readyLow;
        exp = refShift(t, isReg, imm, rf[addr][7:0], rm, cin);
        checkOutput("idle_ready", {31'd0, req_ready}, 32'd1);
        applyStimulus(1'b1, t, isReg, imm, addr, rm, cin);
        nextCycle();
        junkRequest(1'b0);
        k        = 1;
        pulses   = 0;
        readyLow = 1'b1;
        while (!res_valid && k < 20) begin
            if (rs_rd_en) begin
                pulses++;
                checkOutput("rs_rd_addr", {28'd0, rs_rd_addr}, {28'd0, addr});
            end
            if (req_ready) readyLow = 1'b0;
            nextCycle();
            k++;
        end
        if (req_ready) readyLow = 1'b0;
        checkOutput("latency", 32'(k), isReg ? 32'(3 + LAT) : 32'd2);
        checkOutput("rd_pulses", 32'(pulses), {31'd0, isReg});
        checkOutput("busy_ready_low", {31'd0, readyLow}, 32'd1);
        checkOutput("res_data", res_data, exp[31:0]);
`ifdef SHIFT_CARRY_OUT_EN
        checkOutput("res_carry", {31'd0, res_carry}, {31'd0, exp[32]});
`endif
        for (int h = 0; h < hold; h++) begin
            junkRequest(1'($urandom()));
            nextCycle();
            checkOutput("hold_data", res_data, exp[31:0]);
            checkOutput("hold_valid_ready", {30'd0, res_valid, req_ready}, 32'd2);
            checkOutput("hold_no_read", {31'd0, rs_rd_en}, 32'd0);
        end
        req_valid = 1'b0;
        res_ready = 1'b1;
        nextCycle();
        res_ready = 1'b0;
        checkOutput("release_idle", {30'd0, res_valid, req_ready}, 32'd1);
    endtask

    // Directed steps followed by randomized requests.
    initial begin
        int amts [3];
        logic seenValid;
        logic [7:0] a;
        amts = '{32, 33, 255};
        for (int i = 0; i < 4; i++) begin
            pipeEn[i]   = 1'b0;
            pipeAddr[i] = 4'd0;
        end
        for (int i = 0; i < 16; i++) rf[i] = $urandom();
        rs_rd_data = 32'd0;
        res_ready  = 1'b0;
        applyStimulus(1'b0, 2'd0, 1'b0, 5'd0, 4'd0, 32'd0, 1'b0);
        reset = 1'b0;
        #1;
        checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("rst_rs_rd_en", {31'd0, rs_rd_en}, 32'd0);
        checkOutput("rst_rs_rd_addr", {28'd0, rs_rd_addr}, 32'd0);
        checkOutput("rst_res_valid", {31'd0, res_valid}, 32'd0);
        checkOutput("rst_res_data", res_data, 32'd0);
        nextCycle();
        nextCycle();
        reset = 1'b1;
        nextCycle();

        $display("[TB] immediate shifts");
        runOp(2'b00, 1'b0, 5'd4, 4'd0, 32'h0000_00F1, 1'b0, 0);
        runOp(2'b01, 1'b0, 5'd0, 4'd0, 32'h8000_0001, 1'b1, 0);
        runOp(2'b10, 1'b0, 5'd0, 4'd0, 32'h8000_0001, 1'b1, 0);
        runOp(2'b11, 1'b0, 5'd0, 4'd0, 32'h8000_0001, 1'b1, 0);
        runOp(2'b00, 1'b0, 5'd0, 4'd0, 32'h8000_0001, 1'b1, 0);

        $display("[TB] register shifts");
        rf[5] = 32'h0000_0108;
        runOp(2'b11, 1'b1, 5'd0, 4'd5, 32'h1234_5678, 1'b0, 1);
        for (int i = 0; i < 3; i++) begin
            for (int t = 0; t < 3; t++) begin
                rf[3] = 32'(amts[i]);
                runOp(2'(t), 1'b1, 5'($urandom()), 4'd3, 32'h8000_0000, 1'($urandom()), 0);
            end
        end
        rf[7] = 32'h0000_0300;
        for (int t = 0; t < 4; t++) begin
            runOp(2'(t), 1'b1, 5'd9, 4'd7, 32'hA5A5_0F0F, 1'($urandom()), 0);
        end

        $display("[TB] backpressure");
        runOp(2'b10, 1'b0, 5'd7, 4'd0, 32'h8000_1234, 1'b0, 5);

        $display("[TB] reset during Rs wait");
        rf[9] = 32'h0000_0004;
        applyStimulus(1'b1, 2'b11, 1'b1, 5'd0, 4'd9, 32'hDEAD_BEEF, 1'b0);
        nextCycle();
        junkRequest(1'b0);
        checkOutput("mid_rs_req", {31'd0, rs_rd_en}, 32'd1);
        nextCycle();
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("async_rs_rd_en", {31'd0, rs_rd_en}, 32'd0);
        checkOutput("async_res_valid", {31'd0, res_valid}, 32'd0);
        checkOutput("async_res_data", res_data, 32'd0);
        nextCycle();
        nextCycle();
        reset = 1'b1;
        seenValid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            nextCycle();
            seenValid = seenValid | res_valid;
        end
        checkOutput("abort_no_result", {31'd0, seenValid}, 32'd0);
        runOp(2'b11, 1'b1, 5'd0, 4'd9, 32'hDEAD_BEEF, 1'b0, 0);

        $display("[TB] randomized requests");
        for (int r = 0; r < 40; r++) begin
            case ($urandom_range(0, 4))
                0:       a = 8'd0;
                1:       a = 8'd32;
                2:       a = 8'($urandom_range(33, 255));
                3:       a = 8'(32 * $urandom_range(1, 7));
                default: a = 8'($urandom_range(1, 31));
            endcase
            rf[r % 16] = ($urandom() & 32'hFFFF_FF00) | {24'd0, a};
            runOp(2'($urandom()), 1'($urandom()),
                  ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom()),
                  4'(r % 16), $urandom(), 1'($urandom()), $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle controller in front of the operand-2 shift path.
- Accepts one shift request at a time over a valid/ready handshake.
- For register-specified shifts, fetches Rs through a dedicated register-file read port, waiting a parameterised latency.
- Applies ARM shift semantics: immediate-zero encodings, saturation of amounts of 32 or more, RRX. Returns the result over a valid/ready handshake to the execute stage.

Parameters:
- RS_READ_LATENCY, 1, cycles from rs_rd_en to valid rs_rd_data; legal 1..3.
- DATA_WIDTH, 32, operand width; only 32 is supported.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset; asserted at 0.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept a request.
- req_type  input  2  shift type: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
- req_reg_shift  input  1  1 = amount taken from Rs[7:0]; 0 = amount taken from req_imm_amount.
- req_imm_amount  input  5  immediate shift amount.
- req_rs_addr  input  4  Rs register index.
- req_rm_data  input  32  Rm operand value.
- carry_in  input  1  current C flag; sampled with the request.
- rs_rd_en  output  1  one-cycle Rs read strobe.
- rs_rd_addr  output  4  Rs read address; valid while rs_rd_en is high.
- rs_rd_data  input  32  Rs value; valid RS_READ_LATENCY cycles after rs_rd_en.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts the result.
- res_data  output  32  shifted result.

Behaviour:
- States: IDLE, RS_REQ, RS_WAIT, EXEC, DONE.
- Reset values: state=IDLE, req_ready=1, rs_rd_en=0, rs_rd_addr=0, res_valid=0, res_data=0.
- Reset asserted mid-operation aborts the operation: state returns to IDLE and the in-flight request is discarded with no result.
- req_ready is 1 only in IDLE. On req_valid&&req_ready, latch type, reg_shift, imm_amount, rs_addr, rm_data and carry_in.
- IDLE transitions: to RS_REQ if req_reg_shift=1, otherwise to EXEC.
- RS_REQ: drive rs_rd_en=1 and rs_rd_addr for exactly one cycle, load the wait counter with RS_READ_LATENCY-1, then go to RS_WAIT.
- RS_WAIT: decrement the counter. When it reaches 0, capture rs_rd_data[7:0] as the amount and go to EXEC.
- EXEC: compute and register res_data, go to DONE.
- DONE: res_valid=1. res_data is held stable until res_ready=1, then state returns to IDLE. No bypass from DONE to a new accept in the same cycle.
- Latency from accept cycle N: immediate shift, res_valid first high at N+2; register shift, at N+3+RS_READ_LATENCY.
- Immediate amount rules:
  - LSL #0 gives Rm unchanged.
  - LSR #0 means LSR #32, result 0.
  - ASR #0 means ASR #32, all bits = Rm[31].
  - ROR #0 means RRX, result {carry_in, Rm[31:1]}.
- Register amount rules (8-bit amount):
  - Amount 0 gives Rm unchanged for every type.
  - LSL/LSR with amount 32 or more give 0.
  - ASR with amount 32 or more gives all bits = Rm[31].
  - ROR rotates by amount[4:0]; amount[4:0]=0 with a nonzero amount gives Rm unchanged.
- ASR is a true arithmetic shift; the Rm sign is explicitly replicated.
- req_valid is ignored outside IDLE. rs_rd_data is ignored outside the capture cycle.

Optional Feature:
- SHIFT_CARRY_OUT_EN defined: adds output port res_carry (1 bit), reset 0, registered in EXEC alongside res_data.
  - Value is the last bit shifted out, per ARM rules.
  - Immediate LSL #0 and register amount 0 pass carry_in through.
  - LSL #32 gives Rm[0]; LSR #32 gives Rm[31]; amounts over 32 give 0 for LSL/LSR.
  - ASR with amount 32 or more gives Rm[31]. RRX gives Rm[0]. ROR with amount[4:0]=0 and a nonzero amount gives Rm[31].
- Not defined: port absent; no carry logic is built.

Test Plan:
- Immediate LSL: req_type=00, imm=4, Rm=0x0000_00F1, accepted at N -> res_valid at N+2, res_data=0x0000_0F10; req_ready low at N+1..N+2, back to 1 the cycle after handshake.
- Immediate zero encodings: Rm=0x8000_0001, carry_in=1 -> LSR #0 gives 0x0; ASR #0 gives 0xFFFF_FFFF; ROR #0 gives 0xC000_0000 (res_carry=1 when enabled).
- Register shift, RS_READ_LATENCY=2: Rs=0x0000_0108 (amount 8), ROR, Rm=0x1234_5678 -> rs_rd_en high exactly one cycle with rs_rd_addr=req_rs_addr; res_valid at N+5; res_data=0x7812_3456.
- Register saturation: amounts 32, 33, 255 with Rm=0x8000_0000 -> LSL gives 0; LSR gives 0; ASR gives 0xFFFF_FFFF; register amount 0 gives Rm unchanged.
- Backpressure: hold res_ready=0 for 5 cycles in DONE while toggling req_valid -> res_data stable, req_ready=0, no new accept; release -> return to IDLE next cycle.
- Reset mid-operation: drive reset=0 asynchronously while in RS_WAIT -> outputs return to reset values immediately without a clock edge; no res_valid after release; next request completes normally.
